mem_data_access: RTL and testbench
==================================

Name: mem_data_access

Overview:
MEM-stage load/store engine. Consumes the EXE/MEM pipeline register outputs (address, store data, load/store type) and drives the data-side SRAM-like bus (addr_ok/data_ok handshake). It also produces the aligned, extended load result for the MEM/WB register. It stalls the pipeline while a transaction is outstanding and drains abandoned transactions after a flush.

Parameters:
ADDR_W, 32, data bus address width
DATA_W, 32, data bus width; fixed at 32 (byte enables are 4 bits)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
mem_valid  in  1  instruction in MEM is valid
mem_flush  in  1  exception/flush kills the current MEM instruction
mem_advance  in  1  downstream accepts the MEM result this cycle
mem_aluout  in  32  effective address
mem_outb  in  32  store data (rt)
mem_load_type  in  3  [1:0] size: 00 none, 01 byte, 10 half, 11 word; [2] sign-extend
mem_store_type  in  2  size: 00 none, 01 byte, 10 half, 11 word
data_req  out  1  bus request
data_wr  out  1  1 = write
data_addr  out  32  word-aligned address
data_be  out  4  byte enables
data_wdata  out  32  lane-replicated store data
data_addr_ok  in  1  address accepted
data_data_ok  in  1  read data valid / write complete
data_rdata  in  32  read data
load_result  out  32  extended load data, stable in DONE
mem_stall  out  1  hold IF..MEM
addr_exc  out  2  00 none, 01 AdEL, 10 AdES (only with the optional feature)

Behaviour:
- Access present = mem_valid & (load size≠00 | store size≠00) & ~mem_flush. If both load and store are encoded, store wins.
- FSM states:
  - IDLE: on access (and no address exception) go to REQ in the same cycle; data_req is asserted combinationally.
  - REQ: data_req=1; on data_addr_ok go to WAIT. If data_addr_ok arrives together with data_data_ok, go directly to DONE.
  - WAIT: data_req=0; on data_data_ok capture rdata and go to DONE.
  - DONE: mem_stall=0; hold load_result; on mem_advance go to IDLE.
  - DRAIN: discard; on data_data_ok go to IDLE.
- mem_stall = access & state≠DONE, or state=DRAIN. A zero-wait bus therefore costs 1 stall cycle minimum (REQ with data_ok same cycle → DONE).
- data_addr = {mem_aluout[31:2],2'b00}. data_addr, data_be, data_wr and data_wdata are held stable while data_req=1 and not acked.
- Byte enables from addr[1:0]:
  - Byte: 0001<<a.
  - Half: 0011 (a=0) or 1100 (a=2).
  - Word: 1111.
  - Loads also drive byte enables.
- wdata: byte replicated ×4, half replicated ×2, word as is.
- Load extract: select lane by addr[1:0] (latched at request), then zero- or sign-extend per load_type[2].
- mem_flush:
  - In REQ before addr_ok: drop request next cycle, go to IDLE.
  - In REQ with addr_ok, or in WAIT: go to DRAIN (data must not reach WB).
  - In DONE: go to IDLE.
- A new access arriving while in DRAIN waits until DRAIN completes.
- Reset values (async, rst=0): state IDLE, data_req 0, data_wr 0, data_addr 0, data_be 0, data_wdata 0, load_result 0, mem_stall 0, addr_exc 0.
- Reset mid-transaction abandons it; the bus side is reset concurrently.

Optional Feature:
MEM_UNALIGNED_EXC_EN.
- Defined: misaligned access (half with a[0]=1, word with a[1:0]≠0) raises addr_exc combinationally in the same cycle (AdEL for load, AdES for store). No bus request is issued, mem_stall=0, and the FSM stays in IDLE.
- Undefined: addr_exc tied 00. Misaligned half/word accesses are forced aligned by clearing the offending low address bits.

Test Plan:
1. Zero-wait LW @0x0000_1004: addr_ok and data_ok in the same cycle, rdata=0xDEADBEEF → data_be=1111, 1 stall cycle, load_result=0xDEADBEEF.
2. LB signed @0x...03, rdata=0x80FF_FF7F → load_result=0xFFFF_FF80. Same with LBU → 0x0000_0080.
3. SH @0x...02, rt=0x1234_ABCD, addr_ok delayed 3 cycles → data_be=1100, wdata=0xABCD_ABCD held stable for 3 cycles, mem_stall high until data_ok.
4. Flush after addr_ok, before data_ok (data_ok 2 cycles later) → state DRAIN, stall held; next load's request is not issued until the stale data_ok, and its data is not taken from the stale response.
5. With MEM_UNALIGNED_EXC_EN: LW @0x...02 → addr_exc=01, data_req never asserted. Without the macro → data_addr=0x...00, normal load.
6. rst pulled low while in WAIT → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/mem_data_access.sv
// mem_data_access: MEM-stage load/store engine for an SRAM-like data bus
// with an addr_ok/data_ok handshake. It stalls the pipeline while a
// transaction is outstanding and drains responses abandoned by a flush.
// It also aligns and extends load data for the MEM/WB register.
// Build option: define MEM_UNALIGNED_EXC_EN to report misaligned half/word
// accesses on addr_exc (AdEL/AdES) instead of forcing them aligned.
module mem_data_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_flush,
    input  logic              mem_advance,
    input  logic [ADDR_W-1:0] mem_aluout,
    input  logic [DATA_W-1:0] mem_outb,
    input  logic [2:0]        mem_load_type,
    input  logic [1:0]        mem_store_type,
    output logic              data_req,
    output logic              data_wr,
    output logic [ADDR_W-1:0] data_addr,
    output logic [3:0]        data_be,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [DATA_W-1:0] load_result,
    output logic              mem_stall,
    output logic [1:0]        addr_exc
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

    state_t            r_state, w_next;
    logic              w_is_store, w_access, w_exc, w_go;
    logic              w_req, w_capture, w_in_idle;
    logic [1:0]        w_size, w_off;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [ADDR_W-1:0] w_addr;

    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic              r_wr;
    logic [DATA_W-1:0] r_wdata;
    logic [1:0]        r_off, r_size;
    logic              r_sext;
    logic [DATA_W-1:0] r_load_result;

    logic [1:0]        w_cur_off, w_cur_size;
    logic              w_cur_sext, w_cur_wr;

    // A store encoding takes priority over a simultaneous load encoding
    assign w_is_store = |mem_store_type;
    assign w_size     = w_is_store ? mem_store_type : mem_load_type[1:0];
    assign w_access   = mem_valid & (|w_size) & ~mem_flush;
    assign w_addr     = {mem_aluout[ADDR_W-1:2], 2'b00};

`ifdef MEM_UNALIGNED_EXC_EN
    logic w_misalign;
    assign w_misalign = ((w_size == 2'b10) & mem_aluout[0]) |
                        ((w_size == 2'b11) & (|mem_aluout[1:0]));
    assign w_exc      = w_access & w_misalign;
    assign w_off      = mem_aluout[1:0];
    assign addr_exc   = (rst & w_exc) ? (w_is_store ? 2'b10 : 2'b01) : 2'b00;
`else
    // Misaligned half/word accesses silently drop the offending offset bits
    assign w_exc    = 1'b0;
    assign w_off    = (w_size == 2'b11) ? 2'b00 :
                      (w_size == 2'b10) ? {mem_aluout[1], 1'b0} : mem_aluout[1:0];
    assign addr_exc = 2'b00;
`endif

    assign w_go      = w_access & ~w_exc;
    assign w_in_idle = (r_state == S_IDLE);

    // In IDLE the request is built straight from the pipeline inputs; afterwards from the latched copy
    assign w_cur_off  = w_in_idle ? w_off             : r_off;
    assign w_cur_size = w_in_idle ? w_size            : r_size;
    assign w_cur_sext = w_in_idle ? mem_load_type[2]  : r_sext;
    assign w_cur_wr   = w_in_idle ? w_is_store        : r_wr;

    // Select the addressed lane and zero/sign-extend it
    function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] rd,
                                                      input logic [1:0]        off,
                                                      input logic [1:0]        size,
                                                      input logic              sext);
        logic [DATA_W-1:0] sh;
        sh = rd >> {off, 3'b000};
        case (size)
            2'b01:   extend_load = {{24{sext & sh[7]}}, sh[7:0]};
            2'b10:   extend_load = {{16{sext & sh[15]}}, sh[15:0]};
            default: extend_load = sh;
        endcase
    endfunction

    // Byte enables and lane-replicated store data for the access presented now
    always_comb begin
        // NOTE: every always_comb output is given a default first so no path can infer a latch.
        w_be    = 4'b0000;
        w_wdata = '0;
        case (w_size)
            2'b01: begin
                w_be    = 4'b0001 << w_off;
                w_wdata = {4{mem_outb[7:0]}};
            end
            2'b10: begin
                w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{mem_outb[15:0]}};
            end
            2'b11: begin
                w_be    = 4'b1111;
                w_wdata = mem_outb;
            end
            default: ;
        endcase
    end

    // Next-state, bus request and read-data capture decisions
    always_comb begin
        w_next    = r_state;
        w_req     = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_go) begin
                    w_req = 1'b1;
                    if (data_addr_ok && data_data_ok) begin
                        w_next    = S_DONE;
                        w_capture = 1'b1;
                    end else if (data_addr_ok) begin
                        w_next = S_WAIT;
                    end else begin
                        w_next = S_REQ;
                    end
                end
            end
            S_REQ: begin
                w_req = 1'b1;
                if (data_addr_ok) begin
                    if (data_data_ok) begin
                        w_next    = mem_flush ? S_IDLE : S_DONE;
                        w_capture = ~mem_flush;
                    end else begin
                        w_next = mem_flush ? S_DRAIN : S_WAIT;
                    end
                end else if (mem_flush) begin
                    w_next = S_IDLE;
                end
            end
            S_WAIT: begin
                if (data_data_ok) begin
                    w_next    = mem_flush ? S_IDLE : S_DONE;
                    w_capture = ~mem_flush;
                end else if (mem_flush) begin
                    w_next = S_DRAIN;
                end
            end
            S_DONE: begin
                if (mem_advance || mem_flush) w_next = S_IDLE;
            end
            S_DRAIN: begin
                if (data_data_ok) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Bus outputs are forced to zero whenever no request is on the bus (including reset)
    assign data_req    = rst & w_req;
    assign data_wr     = data_req & w_cur_wr;
    assign data_addr   = data_req ? (w_in_idle ? w_addr  : r_addr)  : '0;
    assign data_be     = data_req ? (w_in_idle ? w_be    : r_be)    : 4'b0000;
    assign data_wdata  = data_req ? (w_in_idle ? w_wdata : r_wdata) : '0;
    assign mem_stall   = rst & ((w_go & (r_state != S_DONE)) | (r_state == S_DRAIN));
    assign load_result = r_load_result;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Latch the request fields as the access leaves IDLE so they hold until accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_be    <= 4'b0000;
            r_wr    <= 1'b0;
            r_wdata <= '0;
            r_off   <= 2'b00;
            r_size  <= 2'b00;
            r_sext  <= 1'b0;
        end else if (w_in_idle && w_go) begin
            r_addr  <= w_addr;
            r_be    <= w_be;
            r_wr    <= w_is_store;
            r_wdata <= w_wdata;
            r_off   <= w_off;
            r_size  <= w_size;
            r_sext  <= mem_load_type[2];
        end
    end

    // Capture and extend load data on the completing data_ok
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_load_result <= '0;
        end else if (w_capture && !w_cur_wr) begin
            r_load_result <= extend_load(data_rdata, w_cur_off, w_cur_size, w_cur_sext);
        end
    end

endmodule

// File: tb/tb_mem_data_access.sv
// tb_mem_data_access: self-checking bench for mem_data_access. A cycle-level
// bus responder drives addr_ok/data_ok with programmable delays; expected
// load results are queued when an access is driven and popped in DONE.
module tb_mem_data_access;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_flush;
    logic        mem_advance;
    logic [31:0] mem_aluout;
    logic [31:0] mem_outb;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_store_type;
    logic        data_req;
    logic        data_wr;
    logic [31:0] data_addr;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [31:0] load_result;
    logic        mem_stall;
    logic [1:0]  addr_exc;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] q_exp[$];

    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    mem_data_access #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_valid      (mem_valid),
        .mem_flush      (mem_flush),
        .mem_advance    (mem_advance),
        .mem_aluout     (mem_aluout),
        .mem_outb       (mem_outb),
        .mem_load_type  (mem_load_type),
        .mem_store_type (mem_store_type),
        .data_req       (data_req),
        .data_wr        (data_wr),
        .data_addr      (data_addr),
        .data_be        (data_be),
        .data_wdata     (data_wdata),
        .data_addr_ok   (data_addr_ok),
        .data_data_ok   (data_data_ok),
        .data_rdata     (data_rdata),
        .load_result    (load_result),
        .mem_stall      (mem_stall),
        .addr_exc       (addr_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference byte enables (half/word offsets already forced aligned)
    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b01: begin
                case (a)
                    2'd0:    return 4'b0001;
                    2'd1:    return 4'b0010;
                    2'd2:    return 4'b0100;
                    default: return 4'b1000;
                endcase
            end
            2'b10:   return (a >= 2'd2) ? 4'b1100 : 4'b0011;
            2'b11:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b01:   return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
            2'b10:   return {wd[15:0], wd[15:0]};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] sz,
                                               input logic sx, input logic [1:0] a);
        logic [7:0]  b [4];
        logic [7:0]  v8;
        logic [15:0] v16;
        int          lo;
        for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
        case (sz)
            2'b01: begin
                v8 = b[a];
                return sx ? {{24{v8[7]}}, v8} : {24'h0, v8};
            end
            2'b10: begin
                lo  = (a >= 2'd2) ? 2 : 0;
                v16 = {b[lo+1], b[lo]};
                return sx ? {{16{v16[15]}}, v16} : {16'h0, v16};
            end
            default: return rd;
        endcase
    endfunction

    // One complete access: addr_ok after a_dly request cycles, data_ok d_dly cycles after addr_ok
    task automatic do_access(input string tag, input logic [2:0] lt, input logic [1:0] st,
                             input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                             input int a_dly, input int d_dly);
        logic        is_st;
        logic [1:0]  sz;
        logic [31:0] exp_addr, exp_wd, exp_ld;
        logic [3:0]  exp_be;
        int          cyc, acc_cyc, stalls;
        bit          accepted, finished;
        is_st    = (st != 2'b00);
        sz       = is_st ? st : lt[1:0];
        exp_addr = {addr[31:2], 2'b00};
        exp_be   = model_be(sz, addr[1:0]);
        exp_wd   = model_wdata(sz, wd);
        if (!is_st) q_exp.push_back(model_load(rd, sz, lt[2], addr[1:0]));

        @(posedge clk); #1;
        mem_valid      = 1'b1;
        mem_flush      = 1'b0;
        mem_advance    = 1'b0;
        mem_load_type  = lt;
        mem_store_type = st;
        mem_aluout     = addr;
        mem_outb       = wd;
        cyc      = 0;
        acc_cyc  = 0;
        stalls   = 0;
        accepted = 1'b0;
        finished = 1'b0;
        while (!finished && cyc < 40) begin
            data_addr_ok = !accepted && (cyc >= a_dly);
            data_data_ok = accepted ? ((cyc - acc_cyc) >= d_dly) : (data_addr_ok && d_dly == 0);
            data_rdata   = data_data_ok ? rd : JUNK;
            @(negedge clk);
            if (mem_stall) stalls++;
            if (!accepted) begin
                check({tag, " req"},   32'(data_req),   32'd1);
                check({tag, " wr"},    32'(data_wr),    32'(is_st));
                check({tag, " addr"},  data_addr,       exp_addr);
                check({tag, " be"},    32'(data_be),    32'(exp_be));
                check({tag, " exc"},   32'(addr_exc),   32'd0);
                if (is_st) check({tag, " wdata"}, data_wdata, exp_wd);
            end else begin
                check({tag, " wait_req"}, 32'(data_req), 32'd0);
            end
            if (data_addr_ok && !accepted) begin
                accepted = 1'b1;
                acc_cyc  = cyc;
            end
            if (data_data_ok) finished = 1'b1;
            cyc++;
            @(posedge clk); #1;
        end
        if (!finished) check({tag, " timeout"}, 32'd0, 32'd1);
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = JUNK;
        mem_advance  = 1'b1;
        @(negedge clk);
        check({tag, " stall_cycles"}, 32'(stalls), 32'(a_dly + d_dly + 1));
        check({tag, " done_stall"},   32'(mem_stall), 32'd0);
        check({tag, " done_req"},     32'(data_req),  32'd0);
        if (!is_st) check({tag, " load_result"}, load_result, q_exp.pop_front());
        @(posedge clk); #1;
        mem_valid   = 1'b0;
        mem_advance = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " req"},   32'(data_req),   32'd0);
        check({tag, " wr"},    32'(data_wr),    32'd0);
        check({tag, " addr"},  data_addr,       32'd0);
        check({tag, " be"},    32'(data_be),    32'd0);
        check({tag, " wdata"}, data_wdata,      32'd0);
        check({tag, " lres"},  load_result,     32'd0);
        check({tag, " stall"}, 32'(mem_stall),  32'd0);
        check({tag, " exc"},   32'(addr_exc),   32'd0);
    endtask

    initial begin
        // Reset with a word load already presented: every output must still read zero
        rst            = 1'b0;
        mem_valid      = 1'b1;
        mem_flush      = 1'b0;
        mem_advance    = 1'b0;
        mem_aluout     = 32'h0000_1004;
        mem_outb       = 32'h5555_AAAA;
        mem_load_type  = 3'b011;
        mem_store_type = 2'b00;
        data_addr_ok   = 1'b0;
        data_data_ok   = 1'b0;
        data_rdata     = JUNK;
        #3;
        check_all_zero("reset");
        @(posedge clk); #1;
        mem_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;

        // Zero-wait word load
        do_access("lw0", 3'b011, 2'b00, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 0);
        check("lw0 const", load_result, 32'hDEAD_BEEF);

        // Signed and unsigned byte loads from lane 3
        do_access("lb", 3'b101, 2'b00, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 0, 0);
        check("lb const", load_result, 32'hFFFF_FF80);
        do_access("lbu", 3'b001, 2'b00, 32'h0000_1003, 32'h0, 32'h80FF_FF7F, 1, 1);
        check("lbu const", load_result, 32'h0000_0080);

        // Halfword store, addr_ok delayed three cycles
        do_access("sh", 3'b000, 2'b10, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 3, 1);

        // Both encodings present: the store must win
        do_access("both", 3'b011, 2'b01, 32'h0000_2001, 32'h0000_0055, 32'h0, 0, 0);
        check("both lres_kept", load_result, 32'h0000_0080);

        // Halfword loads, signed upper lane and unsigned lower lane
        do_access("lh", 3'b110, 2'b00, 32'h0000_3002, 32'h0, 32'h8001_7FFE, 0, 2);
        check("lh const", load_result, 32'hFFFF_8001);
        do_access("lhu", 3'b010, 2'b00, 32'h0000_3000, 32'h0, 32'h8001_F00E, 2, 0);
        check("lhu const", load_result, 32'h0000_F00E);

        // Flush after addr_ok: the stale response is drained, next load waits for it
        @(posedge clk); #1;
        mem_valid      = 1'b1;
        mem_load_type  = 3'b011;
        mem_store_type = 2'b00;
        mem_aluout     = 32'h0000_2000;
        data_addr_ok   = 1'b1;
        data_data_ok   = 1'b0;
        data_rdata     = JUNK;
        @(negedge clk);
        check("flush req", 32'(data_req), 32'd1);
        check("flush stall0", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        mem_flush    = 1'b1;
        @(negedge clk);
        check("flush wait_req", 32'(data_req), 32'd0);
        check("flush stall1", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;
        mem_flush  = 1'b0;
        mem_aluout = 32'h0000_3000;
        q_exp.push_back(32'h2222_2222);
        data_data_ok = 1'b1;
        data_rdata   = 32'h1111_1111;
        @(negedge clk);
        check("drain req", 32'(data_req), 32'd0);
        check("drain stall", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        data_addr_ok = 1'b1;
        data_data_ok = 1'b1;
        data_rdata   = 32'h2222_2222;
        @(negedge clk);
        check("after_drain req", 32'(data_req), 32'd1);
        check("after_drain addr", data_addr, 32'h0000_3000);
        check("after_drain stall", 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata   = JUNK;
        mem_advance  = 1'b1;
        @(negedge clk);
        check("after_drain done_stall", 32'(mem_stall), 32'd0);
        check("after_drain load_result", load_result, q_exp.pop_front());
        @(posedge clk); #1;
        mem_valid   = 1'b0;
        mem_advance = 1'b0;

`ifdef MEM_UNALIGNED_EXC_EN
        // Misaligned accesses raise an exception and never reach the bus
        @(posedge clk); #1;
        mem_valid      = 1'b1;
        mem_load_type  = 3'b011;
        mem_store_type = 2'b00;
        mem_aluout     = 32'h0000_1002;
        data_addr_ok   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("adel exc", 32'(addr_exc), 32'd1);
            check("adel req", 32'(data_req), 32'd0);
            check("adel stall", 32'(mem_stall), 32'd0);
            @(posedge clk); #1;
        end
        mem_load_type  = 3'b000;
        mem_store_type = 2'b10;
        mem_aluout     = 32'h0000_1001;
        @(negedge clk);
        check("ades exc", 32'(addr_exc), 32'd2);
        check("ades req", 32'(data_req), 32'd0);
        @(posedge clk); #1;
        mem_valid    = 1'b0;
        data_addr_ok = 1'b0;
`else
        // Misaligned word/half accesses are forced aligned
        do_access("lw_mis", 3'b011, 2'b00, 32'h0000_1002, 32'h0, 32'hCAFE_F00D, 0, 1);
        check("lw_mis const", load_result, 32'hCAFE_F00D);
        do_access("lh_mis", 3'b110, 2'b00, 32'h0000_1003, 32'h0, 32'h9ABC_1234, 1, 0);
        check("lh_mis const", load_result, 32'hFFFF_9ABC);
`endif

        // Mixed naturally aligned accesses with random data and delays
        for (int i = 0; i < 8; i++) begin
            logic [31:0] base, rnd, wd;
            logic [1:0]  sz, off;
            logic        ld, sx;
            base = $urandom();
            rnd  = $urandom();
            wd   = $urandom();
            sz   = 2'($urandom_range(1, 3));
            off  = 2'($urandom_range(0, 3));
            if (sz == 2'b10) off[0] = 1'b0;
            else if (sz == 2'b11) off = 2'b00;
            ld = 1'($urandom_range(0, 1));
            sx = 1'($urandom_range(0, 1));
            do_access($sformatf("rnd%0d", i), ld ? {sx, sz} : 3'b000, ld ? 2'b00 : sz,
                      {base[31:2], off}, wd, rnd,
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        // Reset pulled while waiting for data_ok
        @(posedge clk); #1;
        mem_valid      = 1'b1;
        mem_load_type  = 3'b011;
        mem_store_type = 2'b00;
        mem_aluout     = 32'h0000_4000;
        data_addr_ok   = 1'b1;
        @(negedge clk);
        check("rstwait req", 32'(data_req), 32'd1);
        @(posedge clk); #1;
        data_addr_ok = 1'b0;
        @(negedge clk);
        check("rstwait wait_req", 32'(data_req), 32'd0);
        check("rstwait stall", 32'(mem_stall), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("rstwait");
        @(posedge clk); #1;
        mem_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        do_access("post_rst", 3'b011, 2'b00, 32'h0000_5008, 32'h0, 32'h0BAD_CAFE, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
